// File: rtl/mont_mul_param.sv
// Radix-2 Montgomery multiplier: result = A*B*2^-N mod M, one bit of A per cycle; done N+2 cycles after accept.
// Backpressure: start is taken only while ready (IDLE) and never queued; even M returns err after 1 cycle.
module mont_mul_param #(
    parameter int N  = 512,
    parameter int CW = 10
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [N-1:0] result
);

    typedef enum logic [1:0] {IDLE, LOOP, FINAL, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   m_q, m_d;
    logic [N-1:0]   res_q, res_d;
    logic [N+1:0]   c_q, c_d;
    logic [CW-1:0]  i_q, i_d;
    logic           err_q, err_d;
    logic [N+1:0]   t, t2;
    logic [N-1:0]   c_sub;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            res_q   <= '0;
            c_q     <= '0;
            i_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            res_q   <= res_d;
            c_q     <= c_d;
            i_q     <= i_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        // C < 2M keeps T2 < 4M, so N+2 bits never overflow
        t     = c_q + (a_q[0] ? {2'b00, b_q} : '0);
        t2    = t + (t[0] ? {2'b00, m_q} : '0);
        // Only used when M <= C < 2M, so the difference fits in N bits
        c_sub = c_q[N-1:0] - m_q;

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        res_d   = res_q;
        c_d     = c_q;
        i_d     = i_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d   = in_a;
                    b_d   = in_b;
                    m_d   = in_m;
                    c_d   = '0;
                    i_d   = '0;
                    err_d = 1'b0;
                    if (!in_m[0]) begin
                        err_d   = 1'b1;
                        res_d   = '0;
                        state_d = DONE;
                    end else begin
                        state_d = LOOP;
                    end
                end
            end
            LOOP: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    // A is shifted down so bit i is always at position 0
                    c_d = t2 >> 1;
                    a_d = a_q >> 1;
                    i_d = i_q + CW'(1);
                    if (i_q == CW'(N - 1)) begin
                        state_d = FINAL;
                    end
                end
            end
            FINAL: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (c_q >= {2'b00, m_q}) begin
                        res_d = c_sub;
                    end else begin
                        res_d = c_q[N-1:0];
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready  = (state_q == IDLE);
    assign busy   = (state_q == LOOP) || (state_q == FINAL);
    assign done   = (state_q == DONE);
    assign err    = err_q;
    assign result = res_q;

endmodule

// File: tb/tb_mont_mul_param.sv
// Directed bench for mont_mul_param at N=8 (M=13, 2^-8 mod 13 = 3) plus an N=512 random sweep.
module tb_mont_mul_param;

    logic clk;
    logic resetn;
    int   cyc;
    int   checks;
    int   errors;

    logic       start8, abort8, rdy8, busy8, done8, err8;
    logic [7:0] a8, b8, m8, res8;

    logic         start512, abort512, rdy512, busy512, done512, err512;
    logic [511:0] a512, b512, m512, res512;

    mont_mul_param #(.N(8), .CW(4)) u_dut8 (
        .clk    (clk),
        .resetn (resetn),
        .start  (start8),
        .abort  (abort8),
        .in_a   (a8),
        .in_b   (b8),
        .in_m   (m8),
        .ready  (rdy8),
        .busy   (busy8),
        .done   (done8),
        .err    (err8),
        .result (res8)
    );

    mont_mul_param #(.N(512), .CW(10)) u_dut512 (
        .clk    (clk),
        .resetn (resetn),
        .start  (start512),
        .abort  (abort512),
        .in_a   (a512),
        .in_b   (b512),
        .in_m   (m512),
        .ready  (rdy512),
        .busy   (busy512),
        .done   (done512),
        .err    (err512),
        .result (res512)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Runs one N=8 op; lat counts negedges after the accepting edge until done is seen (-1 on timeout).
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                        output int lat, output int acc, output logic [7:0] res, output logic e);
        int w;
        w = 0;
        @(negedge clk);
        while (!rdy8 && w < 50) begin
            @(negedge clk);
            w++;
        end
        a8 = a; b8 = b; m8 = m; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        acc = cyc;
        lat = 1;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done8) lat = -1;
        res = res8;
        e   = err8;
    endtask

    task automatic test_reset();
        checks++; if (rdy8 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", rdy8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done8); end
        checks++; if (err8 !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err8); end
        checks++; if (res8 !== 8'd0) begin errors++; $display("FAIL reset_result got %0d exp 0", res8); end
        checks++; if (rdy512 !== 1'b1) begin errors++; $display("FAIL reset_ready512 got %b exp 1", rdy512); end
    endtask

    task automatic test_basic();
        int lat, acc; logic [7:0] res; logic e;
        run8(8'd5, 8'd7, 8'd13, lat, acc, res, e);
        checks++; if (lat !== 10) begin errors++; $display("FAIL basic_latency got %0d exp 10", lat); end
        checks++; if (res !== 8'd1) begin errors++; $display("FAIL basic_result got %0d exp 1", res); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", e); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] av [3] = '{8'd12, 8'd0, 8'd1};
        logic [7:0] bv [3] = '{8'd12, 8'd9, 8'd1};
        logic [7:0] ev [3] = '{8'd3, 8'd0, 8'd3};
        int lat, acc, prev; logic [7:0] res; logic e;
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            run8(av[k], bv[k], 8'd13, lat, acc, res, e);
            checks++; if (res !== ev[k]) begin errors++; $display("FAIL b2b_result%0d got %0d exp %0d", k, res, ev[k]); end
            checks++; if (lat !== 10) begin errors++; $display("FAIL b2b_latency%0d got %0d exp 10", k, lat); end
            if (k > 0) begin
                checks++; if (acc - prev !== 11) begin errors++; $display("FAIL b2b_spacing%0d got %0d exp 11", k, acc - prev); end
            end
            prev = acc;
        end
    endtask

    task automatic test_even_modulus();
        int lat, acc; logic [7:0] res; logic e;
        run8(8'd5, 8'd7, 8'd12, lat, acc, res, e);
        checks++; if (lat !== 1) begin errors++; $display("FAIL even_latency got %0d exp 1", lat); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL even_err got %b exp 1", e); end
        checks++; if (res !== 8'd0) begin errors++; $display("FAIL even_result got %0d exp 0", res); end
        run8(8'd5, 8'd7, 8'd13, lat, acc, res, e);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL even_next_err got %b exp 0", e); end
        checks++; if (res !== 8'd1) begin errors++; $display("FAIL even_next_result got %0d exp 1", res); end
    endtask

    task automatic test_abort();
        logic [7:0] prev_res;
        int seen, lat;
        // Previous completed op (5*7 mod 13) left result=1
        prev_res = 8'd1;
        @(negedge clk);
        a8 = 8'd12; b8 = 8'd12; m8 = 8'd13; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        abort8 = 1'b1;
        @(negedge clk);
        abort8 = 1'b0;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy8); end
        checks++; if (rdy8 !== 1'b1) begin errors++; $display("FAIL abort_ready got %b exp 1", rdy8); end
        checks++; if (res8 !== prev_res) begin errors++; $display("FAIL abort_result got %0d exp %0d", res8, prev_res); end
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            if (done8) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", seen); end

        // A start pulse (with different inputs) during busy must be ignored
        a8 = 8'd0; b8 = 8'd9; m8 = 8'd13; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        lat = 1;
        @(negedge clk); lat++;
        checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL ignore_busy got %b exp 1", busy8); end
        a8 = 8'd1; b8 = 8'd1; m8 = 8'd12; start8 = 1'b1;
        @(negedge clk); lat++;
        start8 = 1'b0;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 10) begin errors++; $display("FAIL ignore_latency got %0d exp 10", lat); end
        checks++; if (res8 !== 8'd0) begin errors++; $display("FAIL ignore_result got %0d exp 0", res8); end
        checks++; if (err8 !== 1'b0) begin errors++; $display("FAIL ignore_err got %b exp 0", err8); end
    endtask

    task automatic test_reset_mid_op();
        int lat, acc; logic [7:0] res; logic e;
        @(negedge clk);
        a8 = 8'd5; b8 = 8'd7; m8 = 8'd13; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++; if (rdy8 !== 1'b1) begin errors++; $display("FAIL arst_ready got %b exp 1", rdy8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL arst_busy got %b exp 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL arst_done got %b exp 0", done8); end
        checks++; if (res8 !== 8'd0) begin errors++; $display("FAIL arst_result got %0d exp 0", res8); end
        @(negedge clk);
        resetn = 1'b1;
        run8(8'd12, 8'd12, 8'd13, lat, acc, res, e);
        checks++; if (res !== 8'd3) begin errors++; $display("FAIL arst_after_result got %0d exp 3", res); end
        checks++; if (lat !== 10) begin errors++; $display("FAIL arst_after_latency got %0d exp 10", lat); end
    endtask

    task automatic test_random_512();
        logic [1023:0] lhs, rhs, mw;
        int lat;
        for (int n = 0; n < 24; n++) begin
            for (int k = 0; k < 16; k++) begin
                m512[k*32 +: 32] = $urandom;
                a512[k*32 +: 32] = $urandom;
                b512[k*32 +: 32] = $urandom;
            end
            m512[511] = 1'b1;
            m512[0]   = 1'b1;
            a512 = a512 % m512;
            b512 = b512 % m512;
            @(negedge clk);
            start512 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start512 = 1'b0;
            lat = 1;
            while (!done512 && lat < 600) begin
                @(negedge clk);
                lat++;
            end
            mw  = {512'd0, m512};
            // result*2^512 must equal A*B modulo M
            lhs = ({512'd0, res512} << 512) % mw;
            rhs = ({512'd0, a512} * {512'd0, b512}) % mw;
            checks++; if (lat !== 514) begin errors++; $display("FAIL rnd%0d_latency got %0d exp 514", n, lat); end
            checks++; if (res512 >= m512) begin errors++; $display("FAIL rnd%0d_range result %h not below M %h", n, res512[63:0], m512[63:0]); end
            checks++; if (lhs !== rhs) begin errors++; $display("FAIL rnd%0d_value got %h exp %h", n, lhs[63:0], rhs[63:0]); end
        end
    endtask

    initial begin
        cyc = 0; checks = 0; errors = 0;
        resetn = 1'b0;
        start8 = 1'b0; abort8 = 1'b0; a8 = '0; b8 = '0; m8 = '0;
        start512 = 1'b0; abort512 = 1'b0; a512 = '0; b512 = '0; m512 = '0;
        repeat (3) @(negedge clk);
        test_reset();
        resetn = 1'b1;
        test_basic();
        test_back_to_back();
        test_even_modulus();
        test_abort();
        test_reset_mid_op();
        test_random_512();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
